// File: rtl/writeback_register_file.sv
// Write-back stage: commits MEM/WB results into the 32x32 register file,
// serves two ID-stage reads with write bypass, and latches the last commit.
module writeback_register_file #(
    parameter int WE_BIT   = 13,
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] control_signals,
    input  logic [31:0] mem_wb_out,
    input  logic [4:0]  destination,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        wb_valid,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data
);

    logic [31:0] regs [NUM_REGS];
    logic        we;
    logic        unused_ctrl;

    // Gating with reset keeps the bypass quiet while the array is held clear.
    assign we = reset && control_signals[WE_BIT] && (destination != 5'd0);

    assign unused_ctrl = ^(control_signals & ~(24'd1 << WE_BIT));

    always_comb begin
        rs_data = '0;
        if (rs_addr != 5'd0) begin
            if (we && (destination == rs_addr)) begin
                rs_data = mem_wb_out;
            end else begin
                rs_data = regs[rs_addr];
            end
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_addr != 5'd0) begin
            if (we && (destination == rt_addr)) begin
                rt_data = mem_wb_out;
            end else begin
                rt_data = regs[rt_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wb_valid <= 1'b0;
            wb_dest  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= we;
            if (we) begin
                regs[destination] <= mem_wb_out;
                wb_dest           <= destination;
                wb_data           <= mem_wb_out;
            end
        end
    end

endmodule
